// File: rtl/sonar_pkg.sv
// Purpose: shared state encoding and ASCII constants for the sonar scan sequencer.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package sonar_pkg;

  // FSM state encoding, also exported on db_estado.
  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    POSICIONA = 4'd1,
    MEDE      = 4'd2,
    AGUARDA   = 4'd3,
    TRANSMITE = 4'd4,
    ESPERA_TX = 4'd5,
    PROXIMO   = 4'd6
  } estado_t;

  localparam logic [6:0] ASCII_VIRGULA   = 7'h2C;  // ','
  localparam logic [6:0] ASCII_CERQUILHA = 7'h23;  // '#'
  localparam logic [6:0] ASCII_INTERROG  = 7'h3F;  // '?'
  localparam logic [2:0] PREFIXO_DIGITO  = 3'b011; // upper bits of '0'..'9'

  // Index of the last character of an 8-character frame.
  localparam logic [2:0] ULTIMO_CHAR = 3'd7;

  // One BCD nibble to its ASCII digit.
  function automatic logic [6:0] digito_ascii(input logic [3:0] bcd);
    return {PREFIXO_DIGITO, bcd};
  endfunction

endpackage

// File: rtl/sonar_timer.sv
// Purpose: up-counter shared by the dwell and measurement-timeout waits.
// Latency: fim is combinational; it rises after `limite` counted cycles since zera.
// Backpressure: none; counting is gated by conta and saturates at limite-1.
// Ports: clock, reset (async, active-low), zera (clear), conta (count enable),
//        limite (terminal count, sampled combinationally), fim (terminal reached).
module sonar_timer #(
  parameter int W = 22
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  input  logic [W-1:0] limite,
  output logic         fim
);

  logic [W-1:0] cnt;

  // fim marks the last cycle of the wait, so a wait of L clocks spans
  // exactly L cycles of the calling state.
  assign fim = (cnt == (limite - W'(1)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (zera) begin
      cnt <= '0;
    end else if (conta && !fim) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/sonar_scan_seq.sv
// Purpose: sonar sweep sequencer: positions servo, requests a distance, sends an 8-char frame.
// Latency: per position DWELL clocks settle, <=TIMEOUT clocks measure, then 8 UART handshakes.
// Backpressure: each character waits indefinitely for tx_pronto; no UART timeout.
// Ports: clock, reset (async, active-low); ligar/modo control; posicao/angulo servo+ROM;
//        medir/pronto_medida/medida sensor; tx_dado/tx_partida/tx_pronto UART;
//        fim_varredura, timeout_medida, db_estado status.
module sonar_scan_seq
  import sonar_pkg::*;
#(
  parameter int N_POS   = 8,
  parameter int W_POS   = 3,
  parameter int DWELL   = 600_000,
  parameter int TIMEOUT = 3_000_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ligar,
  input  logic             modo,
  output logic [W_POS-1:0] posicao,
  input  logic [11:0]      angulo,
  output logic             medir,
  input  logic             pronto_medida,
  input  logic [11:0]      medida,
  output logic [6:0]       tx_dado,
  output logic             tx_partida,
  input  logic             tx_pronto,
  output logic             fim_varredura,
  output logic             timeout_medida,
  output logic [3:0]       db_estado
);

  localparam int T_MAX = (DWELL > TIMEOUT) ? DWELL : TIMEOUT;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam logic [W_POS-1:0] POS_MAX = W_POS'(N_POS - 1);

  estado_t          estado, prox;
  logic [2:0]       idx;
  logic             dir_sobe;
  logic [11:0]      ang_lat, dist_lat;

  logic             tm_zera, tm_conta, tm_fim;
  logic [TW-1:0]    tm_limite;

  logic [W_POS-1:0] pos_nx;
  logic             dir_nx, pos_extremo, sobe_ef;
  logic [6:0]       char_atual;

  sonar_timer #(.W(TW)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .zera   (tm_zera),
    .conta  (tm_conta),
    .limite (tm_limite),
    .fim    (tm_fim)
  );

  // Next-state and strobe decode.
  always_comb begin
    prox       = estado;
    medir      = 1'b0;
    tx_partida = 1'b0;
    tm_zera    = 1'b0;
    tm_conta   = 1'b0;
    tm_limite  = TW'(DWELL);
    case (estado)
      INICIAL: begin
        tm_zera = 1'b1;
        if (ligar) prox = POSICIONA;
      end
      POSICIONA: begin
        tm_conta = 1'b1;
        if (!ligar)      prox = INICIAL;
        else if (tm_fim) prox = MEDE;
      end
      MEDE: begin
        medir   = 1'b1;
        tm_zera = 1'b1;
        prox    = AGUARDA;
      end
      AGUARDA: begin
        tm_limite = TW'(TIMEOUT);
        tm_conta  = 1'b1;
        if (pronto_medida || tm_fim) prox = TRANSMITE;
      end
      TRANSMITE: begin
        tx_partida = 1'b1;
        prox       = ESPERA_TX;
      end
      ESPERA_TX: begin
        if (tx_pronto) prox = (idx == ULTIMO_CHAR) ? PROXIMO : TRANSMITE;
      end
      PROXIMO: begin
        tm_zera = 1'b1;
        prox    = ligar ? POSICIONA : INICIAL;
      end
      default: prox = INICIAL;
    endcase
  end

  // Next servo position. The effective direction is recomputed from the
  // current position so a mode change at an end can never over/underflow.
  always_comb begin
    pos_nx      = posicao;
    dir_nx      = dir_sobe;
    sobe_ef     = 1'b1;
    pos_extremo = 1'b0;
    if (modo) begin
      pos_nx      = (posicao == POS_MAX) ? '0 : posicao + W_POS'(1);
      dir_nx      = 1'b1;
      pos_extremo = (pos_nx == '0);
    end else begin
      sobe_ef     = dir_sobe ? (posicao != POS_MAX) : (posicao == '0);
      pos_nx      = sobe_ef ? posicao + W_POS'(1) : posicao - W_POS'(1);
      dir_nx      = sobe_ef ? (pos_nx != POS_MAX) : (pos_nx == '0);
      pos_extremo = (pos_nx == POS_MAX) || (pos_nx == '0);
    end
  end

  assign fim_varredura = (estado == PROXIMO) && pos_extremo;

  // Frame formatter: character selected by idx from the latched values.
  always_comb begin
    char_atual = 7'h00;
    case (idx)
      3'd0: char_atual = digito_ascii(ang_lat[11:8]);
      3'd1: char_atual = digito_ascii(ang_lat[7:4]);
      3'd2: char_atual = digito_ascii(ang_lat[3:0]);
      3'd3: char_atual = ASCII_VIRGULA;
      3'd4: char_atual = timeout_medida ? ASCII_INTERROG : digito_ascii(dist_lat[11:8]);
      3'd5: char_atual = timeout_medida ? ASCII_INTERROG : digito_ascii(dist_lat[7:4]);
      3'd6: char_atual = timeout_medida ? ASCII_INTERROG : digito_ascii(dist_lat[3:0]);
      default: char_atual = ASCII_CERQUILHA;
    endcase
  end

  // idx and the latches only move on tx_pronto / frame entry, so tx_dado
  // holds from the start pulse until the UART acknowledges.
  assign tx_dado   = ((estado == TRANSMITE) || (estado == ESPERA_TX)) ? char_atual : 7'h00;
  assign db_estado = estado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado         <= INICIAL;
      posicao        <= '0;
      dir_sobe       <= 1'b1;
      idx            <= '0;
      ang_lat        <= '0;
      dist_lat       <= '0;
      timeout_medida <= 1'b0;
    end else begin
      estado <= prox;
      if (estado == MEDE) idx <= '0;
      if (estado == AGUARDA) begin
        // Measurement completion wins over a coinciding timeout.
        if (pronto_medida) begin
          dist_lat       <= medida;
          timeout_medida <= 1'b0;
          ang_lat        <= angulo;
        end else if (tm_fim) begin
          timeout_medida <= 1'b1;
          ang_lat        <= angulo;
        end
      end
      if ((estado == ESPERA_TX) && tx_pronto) idx <= idx + 3'd1;
      if (estado == PROXIMO) begin
        posicao  <= pos_nx;
        dir_sobe <= dir_nx;
      end
    end
  end

endmodule

// File: tb/tb_sonar_scan_seq.sv
// Purpose: self-checking bench for sonar_scan_seq (N_POS=4, DWELL=10, TIMEOUT=50).
// Latency: UART model acks 5 cycles after each start; sensor model answers after sens_dly cycles.
// Backpressure: expected chars/positions/end flags are queued up front and popped as the DUT emits them.
module tb_sonar_scan_seq;

  localparam logic [3:0] S_INICIAL = 4'd0, S_ESPERA = 4'd5, S_PROXIMO = 4'd6;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ligar = 1'b0;
  logic        modo = 1'b0;
  logic [1:0]  posicao;
  logic [11:0] angulo = 12'h045;
  logic        medir;
  logic        pronto_medida = 1'b0;
  logic [11:0] medida = 12'h123;
  logic [6:0]  tx_dado;
  logic        tx_partida;
  logic        tx_pronto = 1'b0;
  logic        fim_varredura;
  logic        timeout_medida;
  logic [3:0]  db_estado;

  sonar_scan_seq #(.N_POS(4), .W_POS(2), .DWELL(10), .TIMEOUT(50)) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .modo(modo), .posicao(posicao),
    .angulo(angulo), .medir(medir), .pronto_medida(pronto_medida), .medida(medida),
    .tx_dado(tx_dado), .tx_partida(tx_partida), .tx_pronto(tx_pronto),
    .fim_varredura(fim_varredura), .timeout_medida(timeout_medida), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] exp_chars[$];
  logic [1:0] exp_pos[$];
  logic       exp_fim[$];

  int n_starts = 0, n_medir = 0, frames_done = 0;
  int uart_cnt = 0, sens_cnt = 0;
  int sens_dly = 3;
  logic sens_en = 1'b1;
  logic [6:0] cur_char = 7'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [11:0] a, input logic [11:0] d, input logic to,
                            input logic [1:0] pos, input logic fim);
    exp_chars.push_back(7'h30 | {3'b000, a[11:8]});
    exp_chars.push_back(7'h30 | {3'b000, a[7:4]});
    exp_chars.push_back(7'h30 | {3'b000, a[3:0]});
    exp_chars.push_back(7'h2C);
    exp_chars.push_back(to ? 7'h3F : (7'h30 | {3'b000, d[11:8]}));
    exp_chars.push_back(to ? 7'h3F : (7'h30 | {3'b000, d[7:4]}));
    exp_chars.push_back(to ? 7'h3F : (7'h30 | {3'b000, d[3:0]}));
    exp_chars.push_back(7'h23);
    exp_pos.push_back(pos);
    exp_fim.push_back(fim);
  endtask

  // Monitor plus UART and sensor responders; checks first, then drives.
  always @(negedge clock) begin
    tx_pronto     = 1'b0;
    pronto_medida = 1'b0;
    if (!reset) begin
      uart_cnt = 0;
      sens_cnt = 0;
    end else begin
      if (tx_partida) begin
        n_starts++;
        check("char_queued", exp_chars.size() != 0, 1);
        if (exp_chars.size() != 0) check("char", tx_dado, exp_chars.pop_front());
        cur_char = tx_dado;
      end
      if (db_estado == S_ESPERA) check("tx_hold", tx_dado, cur_char);
      if (medir) begin
        n_medir++;
        check("pos_queued", exp_pos.size() != 0, 1);
        if (exp_pos.size() != 0) check("posicao", posicao, exp_pos.pop_front());
      end
      if (db_estado == S_PROXIMO) begin
        frames_done++;
        check("fim_queued", exp_fim.size() != 0, 1);
        if (exp_fim.size() != 0) check("fim_varredura", fim_varredura, exp_fim.pop_front());
      end
      if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) tx_pronto = 1'b1;
      end
      if (tx_partida) uart_cnt = 5;
      if (sens_cnt > 0) begin
        sens_cnt--;
        if (sens_cnt == 0 && sens_en) pronto_medida = 1'b1;
      end
      if (medir) sens_cnt = sens_dly;
    end
  end

  task automatic drive_slot();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_frames(input int target, input string tag);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock);
      if (frames_done >= target) begin ok = 1; break; end
    end
    check(tag, ok, 1);
    drive_slot();
  endtask

  task automatic wait_starts(input int target, input string tag);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock);
      if (n_starts >= target) begin ok = 1; break; end
    end
    check(tag, ok, 1);
    drive_slot();
  endtask

  task automatic wait_state(input logic [3:0] st, input string tag);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      drive_slot();
      if (db_estado == st) begin ok = 1; break; end
    end
    check(tag, ok, 1);
  endtask

  task automatic do_reset();
    drive_slot();
    reset = 1'b0;
    drive_slot();
    drive_slot();
    reset = 1'b1;
  endtask

  initial begin
    int fb, sb, mb;
    // Reset state.
    drive_slot();
    check("rst_estado", db_estado, S_INICIAL);
    check("rst_posicao", posicao, 0);
    check("rst_medir", medir, 0);
    check("rst_tx_partida", tx_partida, 0);
    check("rst_tx_dado", tx_dado, 0);
    check("rst_fim", fim_varredura, 0);
    check("rst_timeout", timeout_medida, 0);
    reset = 1'b1;
    drive_slot();

    // Ping-pong sweep: 0,1,2,3,2,1,0,1 with ends at 3 and 0.
    push_frame(12'h045, 12'h123, 0, 0, 0);
    push_frame(12'h045, 12'h123, 0, 1, 0);
    push_frame(12'h045, 12'h123, 0, 2, 1);
    push_frame(12'h045, 12'h123, 0, 3, 0);
    push_frame(12'h045, 12'h123, 0, 2, 0);
    push_frame(12'h045, 12'h123, 0, 1, 1);
    push_frame(12'h045, 12'h123, 0, 0, 0);
    push_frame(12'h045, 12'h123, 0, 1, 0);
    fb = frames_done;
    ligar = 1'b1;
    wait_frames(fb + 8, "pp_frames");
    ligar = 1'b0;
    wait_state(S_INICIAL, "pp_stop");
    check("pp_pos_end", posicao, 2);

    // Sawtooth: 0,1,2,3,0 with the end pulse only on the wrap.
    do_reset();
    modo = 1'b1;
    push_frame(12'h045, 12'h123, 0, 0, 0);
    push_frame(12'h045, 12'h123, 0, 1, 0);
    push_frame(12'h045, 12'h123, 0, 2, 0);
    push_frame(12'h045, 12'h123, 0, 3, 1);
    push_frame(12'h045, 12'h123, 0, 0, 0);
    fb = frames_done;
    ligar = 1'b1;
    wait_frames(fb + 5, "saw_frames");
    ligar = 1'b0;
    wait_state(S_INICIAL, "saw_stop");
    modo = 1'b0;

    // Timeouts: no answer, answer one cycle late, answer on the timeout cycle.
    do_reset();
    sens_en = 1'b0;
    push_frame(12'h045, 12'h123, 1, 0, 0);
    push_frame(12'h045, 12'h123, 1, 1, 0);
    push_frame(12'h180, 12'h987, 0, 2, 1);
    fb = frames_done; sb = n_starts; mb = n_medir;
    ligar = 1'b1;
    wait_frames(fb + 1, "to_f1");
    check("to_medir_once", n_medir - mb, 1);
    check("to_flag_f1", timeout_medida, 1);
    sens_en = 1'b1;
    sens_dly = 51;
    wait_frames(fb + 2, "to_f2");
    check("to_flag_f2", timeout_medida, 1);
    sens_dly = 50;
    medida = 12'h987;
    angulo = 12'h180;
    wait_starts(sb + 17, "to_f3_start");
    angulo = 12'h999;
    wait_frames(fb + 3, "to_f3");
    ligar = 1'b0;
    check("to_flag_clear", timeout_medida, 0);
    wait_state(S_INICIAL, "to_stop");
    angulo = 12'h045;
    medida = 12'h123;
    sens_dly = 3;

    // ligar drops at the 3rd character; the frame still completes.
    do_reset();
    push_frame(12'h045, 12'h123, 0, 0, 0);
    fb = frames_done; sb = n_starts;
    ligar = 1'b1;
    wait_starts(sb + 3, "stop_3rd");
    ligar = 1'b0;
    wait_state(S_INICIAL, "stop_idle");
    check("stop_chars", n_starts - sb, 8);
    check("stop_frames", frames_done - fb, 1);
    check("stop_posicao", posicao, 1);

    // Reset during ESPERA_TX aborts the frame; rerun restarts at char 0.
    push_frame(12'h045, 12'h123, 0, 1, 0);
    sb = n_starts;
    ligar = 1'b1;
    wait_starts(sb + 2, "rm_2nd");
    check("rm_in_espera", db_estado, S_ESPERA);
    reset = 1'b0;
    drive_slot();
    check("rm_estado", db_estado, S_INICIAL);
    check("rm_posicao", posicao, 0);
    check("rm_tx_partida", tx_partida, 0);
    check("rm_tx_dado", tx_dado, 0);
    check("rm_chars_left", exp_chars.size(), 6);
    exp_chars.delete();
    exp_fim.delete();
    push_frame(12'h045, 12'h123, 0, 0, 0);
    fb = frames_done; sb = n_starts;
    reset = 1'b1;
    wait_frames(fb + 1, "rm_rerun");
    ligar = 1'b0;
    wait_state(S_INICIAL, "rm_stop");
    check("rm_rerun_chars", n_starts - sb, 8);

    check("chars_left", exp_chars.size(), 0);
    check("pos_left", exp_pos.size(), 0);
    check("fim_left", exp_fim.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sonar_scan_seq.md
SONAR_SCAN_SEQ -- requirements
Module: sonar_scan_seq

Interface
REQ-001 The block SHALL have parameter N_POS, default 8, giving the number of servo positions per sweep (2..256).
REQ-002 The block SHALL have parameter W_POS, default 3, giving the position width (clog2(N_POS)).
REQ-003 The block SHALL have parameter DWELL, default 600_000, giving the settling clocks at each position before measuring.
REQ-004 The block SHALL have parameter TIMEOUT, default 3_000_000, giving the clocks to wait for pronto_medida.
REQ-005 The block SHALL have port clock  in  1  system clock.
REQ-006 The block SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port ligar  in  1  level; 1 = scan runs.
REQ-008 The block SHALL have port modo  in  1  sweep mode; 0 = ping-pong, 1 = sawtooth (wrap to 0).
REQ-009 The block SHALL have port posicao  out  W_POS  servo position, which also addresses the external angle ROM.
REQ-010 The block SHALL have port angulo  in  12  three BCD digits of the current angle.
REQ-011 The block SHALL have port medir  out  1  one-cycle measurement request to the sensor interface.
REQ-012 The block SHALL have port pronto_medida  in  1  one-cycle measurement-done pulse.
REQ-013 The block SHALL have port medida  in  12  three BCD digits of distance, valid with pronto_medida.
REQ-014 The block SHALL have port tx_dado  out  7  ASCII character to the UART.
REQ-015 The block SHALL have port tx_partida  out  1  one-cycle UART start pulse.
REQ-016 The block SHALL have port tx_pronto  in  1  one-cycle UART done pulse.
REQ-017 The block SHALL have port fim_varredura  out  1  one-cycle pulse when an end position is reached.
REQ-018 The block SHALL have port timeout_medida  out  1  sticky flag: the last measurement timed out.
REQ-019 The block SHALL have port db_estado  out  4  current FSM state encoding.

Function
REQ-020 The FSM SHALL implement the states INICIAL, POSICIONA, MEDE, AGUARDA, TRANSMITE, ESPERA_TX and PROXIMO.
REQ-021 INICIAL SHALL go to POSICIONA when ligar=1, clearing the dwell timer.
REQ-022 POSICIONA SHALL count DWELL clocks, then go to MEDE; if ligar=0 during POSICIONA, the FSM SHALL return to INICIAL.
REQ-023 MEDE SHALL assert medir for exactly 1 cycle, clear the timeout counter, and go to AGUARDA.
REQ-024 AGUARDA SHALL, on pronto_medida, latch medida, clear timeout_medida and go to TRANSMITE.
REQ-025 AGUARDA SHALL, after TIMEOUT clocks with no pronto_medida, set timeout_medida and go to TRANSMITE.
REQ-026 If pronto_medida and the timeout coincide in the same cycle, pronto_medida SHALL win.
REQ-027 Each frame SHALL be 8 characters, in this order: angle hundreds, angle tens, angle units, ',' (0x2C), distance hundreds, distance tens, distance units, '#' (0x23).
REQ-028 Each digit character SHALL equal {3'b011, bcd_nibble}.
REQ-029 On a timed-out measurement, all three distance characters SHALL be '?' (0x3F).
REQ-030 angulo SHALL be latched on entry to TRANSMITE, so the frame stays consistent while posicao is held.
REQ-031 TRANSMITE SHALL pulse tx_partida for 1 cycle, with tx_dado valid that cycle, then go to ESPERA_TX.
REQ-032 tx_dado SHALL remain stable until tx_pronto arrives.
REQ-033 ESPERA_TX SHALL, on tx_pronto, increment the character index: it returns to TRANSMITE if the index is below 7, else goes to PROXIMO.
REQ-034 ESPERA_TX SHALL have no timeout.
REQ-035 PROXIMO SHALL update posicao once per frame; modo SHALL be sampled only in PROXIMO.
REQ-036 In ping-pong mode, posicao SHALL count up to N_POS-1, then down to 0, reversing direction at each end.
REQ-037 In sawtooth mode, posicao SHALL count 0..N_POS-1, then wrap to 0, with direction forced up.
REQ-038 fim_varredura SHALL pulse in the PROXIMO cycle whose new posicao is an end (N_POS-1 or 0 in ping-pong; 0 in sawtooth).
REQ-039 PROXIMO SHALL go to POSICIONA if ligar=1, else to INICIAL; posicao SHALL be retained in INICIAL.
REQ-040 Once started, a frame SHALL always complete: ligar=0 SHALL be ignored from MEDE through ESPERA_TX.
REQ-041 Pulses of pronto_medida outside AGUARDA, and of tx_pronto outside ESPERA_TX, SHALL be ignored.

Reset
REQ-042 On reset=0, the block SHALL asynchronously enter INICIAL and set posicao=0 with direction up.
REQ-043 On reset=0, all counters SHALL clear, and medir, tx_partida, fim_varredura and timeout_medida SHALL be 0.
REQ-044 On reset=0, tx_dado SHALL be 0x00 and the latched distance and angle SHALL be 0x000.
REQ-045 Reset mid-frame SHALL abort the frame; after release, the next frame SHALL start at character 0.

Structure
REQ-046 A shared package sonar_pkg SHALL hold the state encoding and the ASCII constants (comma, hash, question mark, digit prefix 3'b011).
REQ-047 The dwell/timeout timer SHALL be one instance of sub-module sonar_timer (parametrised width, zera/conta/fim), reused for both counts by loading DWELL or TIMEOUT.
REQ-048 The position counter and frame formatter SHALL be inline logic.

Verification (N_POS=4, DWELL=10, TIMEOUT=50)
REQ-049 Ping-pong: with ligar=1 and modo=0, the posicao sequence SHALL be 0,1,2,3,2,1,0,1, and fim_varredura SHALL pulse on reaching 3 and on reaching 0.
REQ-050 Sawtooth: with modo=1, posicao SHALL go 0,1,2,3,0, and fim_varredura SHALL pulse only on the wrap to 0.
REQ-051 Frame: with angulo=0x045, medida=0x123 and the UART returning tx_pronto 5 cycles after each start, the UART SHALL receive "045,123#" as 8 start pulses.
REQ-052 Timeout: with pronto_medida never asserted, medir SHALL pulse once, the frame SHALL be "045,???#", and timeout_medida SHALL be 1 until the next good measurement.
REQ-053 Stop mid-frame: ligar 1->0 at the 3rd character SHALL still complete all 8 characters, then go to INICIAL with posicao advanced by 1.
REQ-054 Reset mid-frame: reset=0 during ESPERA_TX SHALL give, next cycle, db_estado=INICIAL, posicao=0 and tx_partida=0; the rerun SHALL start at character 0.
